// File: rtl/aes_wb_regif.sv
// aes_wb_regif: Wishbone classic slave register block in front of the AES core.
// Decodes key, data-in, control, status and result registers, runs a single
// block operation through a start/done handshake, and raises a level interrupt
// when the operation finishes or times out.
module aes_wb_regif #(
    parameter logic [31:0] BASE_ADDR = 32'hE000_0000,
    parameter int          TIMEOUT   = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [31:0]    wb_adr_i,
    input  logic [31:0]    wb_dat_i,
    input  logic [3:0]     wb_sel_i,
    input  logic           wb_we_i,
    input  logic           wb_cyc_i,
    input  logic           wb_stb_i,
    output logic [31:0]    wb_dat_o,
    output logic           wb_ack_o,
    output logic           wb_err_o,
    output logic           aes_start,
    output logic           aes_mode,
    output logic [127:0]   aes_key,
    output logic [127:0]   aes_din,
    input  logic [127:0]   aes_dout,
    input  logic           aes_done,
    output logic           irq
);

    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_BUSY = 1'b1;

    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    // Register state
    logic [0:0]        r_state;
    logic [31:0]       r_cnt;
    logic              r_start;
    logic              r_mode;
    logic              r_done;
    logic              r_err;
    logic [3:0][31:0]  r_key;
    logic [3:0][31:0]  r_din;
    logic [3:0][31:0]  r_dout;
    logic              r_ack;
    logic              r_errAck;
    logic [31:0]       r_rdata;

    // Decode and control wires
    logic              w_hit;
    logic              w_req;
    logic [7:0]        w_off;
    logic [1:0]        w_idx;
    logic              w_isCtrl;
    logic              w_isStatus;
    logic              w_isKey;
    logic              w_isDin;
    logic              w_isDout;
    logic              w_mapped;
    logic              w_busy;
    logic              w_bad;
    logic              w_wr;
    logic [31:0]       w_rdata;
    logic              w_startWr;
    logic              w_clrDone;
    logic              w_clrErr;
    logic              w_setDone;
    logic              w_setErr;

    // Merge new write data into an existing word, one byte lane per select bit
    function automatic logic [31:0] byteMerge(
        input logic [31:0] oldVal,
        input logic [31:0] newVal,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? newVal[8*b +: 8] : oldVal[8*b +: 8];
        end
        return res;
    endfunction

    assign w_busy     = (r_state == ST_BUSY);
    assign w_off      = wb_adr_i[7:0];
    assign w_idx      = w_off[3:2];
    assign w_hit      = (wb_adr_i[31:8] == BASE_ADDR[31:8]);
    // A new request is only accepted once the previous termination has dropped
    assign w_req      = wb_cyc_i & wb_stb_i & w_hit & ~wb_ack_o & ~wb_err_o;

    assign w_isCtrl   = (w_off == 8'h00);
    assign w_isStatus = (w_off == 8'h04);
    assign w_isKey    = (w_off[7:4] == 4'h1) && (w_off[1:0] == 2'b00);
    assign w_isDin    = (w_off[7:4] == 4'h2) && (w_off[1:0] == 2'b00);
    assign w_isDout   = (w_off[7:4] == 4'h3) && (w_off[1:0] == 2'b00);
    assign w_mapped   = w_isCtrl | w_isStatus | w_isKey | w_isDin | w_isDout;

    // Operand registers are frozen while the core is working so its inputs stay stable
    assign w_bad      = ~w_mapped
                      | (wb_we_i & w_isDout)
                      | (wb_we_i & w_busy & (w_isKey | w_isDin | w_isCtrl));
    assign w_wr       = w_req & wb_we_i & ~w_bad;

    assign w_startWr  = w_wr & w_isCtrl   & wb_sel_i[0] & wb_dat_i[0];
    assign w_clrDone  = w_wr & w_isStatus & wb_sel_i[0] & wb_dat_i[1];
    assign w_clrErr   = w_wr & w_isStatus & wb_sel_i[0] & wb_dat_i[2];

    // Completion takes priority over a timeout that expires in the same cycle
    assign w_setDone  = w_busy & aes_done;
    assign w_setErr   = w_busy & ~aes_done & TO_EN & (r_cnt == TO_LAST);

    // Read data multiplexer for the addressed register
    always_comb begin
        w_rdata = 32'h0;
        if (w_isCtrl) begin
            w_rdata = {30'h0, r_mode, 1'b0};
        end else if (w_isStatus) begin
            w_rdata = {29'h0, r_err, r_done, w_busy};
        end else if (w_isKey) begin
            w_rdata = r_key[w_idx];
        end else if (w_isDin) begin
            w_rdata = r_din[w_idx];
        end else if (w_isDout) begin
            w_rdata = r_dout[w_idx];
        end
    end

    // Registered bus termination; read data is only non-zero during a read ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack    <= 1'b0;
            r_errAck <= 1'b0;
            r_rdata  <= 32'h0;
        end else begin
            r_ack    <= w_req & ~w_bad;
            r_errAck <= w_req & w_bad;
            r_rdata  <= (w_req & ~w_bad & ~wb_we_i) ? w_rdata : 32'h0;
        end
    end

    // Key, data-in and mode registers with per-byte write enables
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key  <= '0;
            r_din  <= '0;
            r_mode <= 1'b0;
        end else if (w_wr) begin
            if (w_isKey) begin
                r_key[w_idx] <= byteMerge(r_key[w_idx], wb_dat_i, wb_sel_i);
            end
            if (w_isDin) begin
                r_din[w_idx] <= byteMerge(r_din[w_idx], wb_dat_i, wb_sel_i);
            end
            if (w_isCtrl && wb_sel_i[0]) begin
                r_mode <= wb_dat_i[1];
            end
        end
    end

    // Operation sequencer: start pulse, cycle counter and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 32'h0;
            r_start <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_startWr) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= 32'h0;
                        r_start <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (w_setDone) begin
                        r_dout  <= aes_dout;
                        r_state <= ST_IDLE;
                    end else if (w_setErr) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky status flags; a set in the same cycle as a clear wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_setDone) begin
                r_done <= 1'b1;
            end else if (w_clrDone) begin
                r_done <= 1'b0;
            end
            if (w_setErr) begin
                r_err <= 1'b1;
            end else if (w_clrErr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign wb_ack_o  = r_ack;
    assign wb_err_o  = r_errAck;
    assign wb_dat_o  = r_rdata;
    assign aes_start = r_start;
    assign aes_mode  = r_mode;
    assign aes_key   = r_key;
    assign aes_din   = r_din;
    assign irq       = r_done | r_err;

endmodule
